// File: rtl/snn_frame_ctrl.sv
// snn_frame_ctrl: host-side frame sequencer for the SNN top level.
//   Accepts UART bytes, unpacks each into 8/PIX_W pixels (LSB first) and
//   writes them into the input-unit RAM. After N_PIX pixels it pulses
//   core_start, waits for core_done and sends the classified digit over TX.
//   A partial frame is aborted when no byte arrives for TO_CYC cycles.
// Ports:
//   clk, rst                  clock, async active-high reset
//   rx_rdy, rx_data           received-byte strobe and data
//   ram_we/ram_addr/ram_wdata pixel write port (addr/data are 0 when idle)
//   core_start, core_done,    core handshake; core_result valid with done
//   core_result
//   tx_start, tx_data, tx_rdy UART transmit request/data, transmitter idle
//   result                    last classified digit, held
//   busy                      low only when idle with no partial frame
//   frame_err                 one-cycle pulse on timeout or overrun
module snn_frame_ctrl #(
  parameter int PIX_W  = 1,
  parameter int N_PIX  = 784,
  parameter int ADDR_W = 10,
  parameter int RES_W  = 4,
  parameter int TO_CYC = 500000,
  parameter int ASCII  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PIX_W-1:0]  ram_wdata,
  output logic              core_start,
  input  logic              core_done,
  input  logic [RES_W-1:0]  core_result,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_rdy,
  output logic [RES_W-1:0]  result,
  output logic              busy,
  output logic              frame_err
);

  localparam int SLICES = 8 / PIX_W;
  localparam int TW     = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(N_PIX - 1);
  localparam logic [3:0]        LAST_SLICE = 4'(SLICES - 1);
  localparam logic [TW-1:0]     TO_LAST    = (TO_CYC > 0) ? TW'(TO_CYC - 1) : '0;

  typedef enum logic [2:0] {
    RX_WAIT, UNPACK, START, CORE, TX, TX_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         shift_q, shift_d;
  logic [ADDR_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [3:0]         slice_cnt_q, slice_cnt_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               guard_q, guard_d;
  logic               frame_err_q, frame_err_d;
  logic [7:0]         tx_enc;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    pix_cnt_d   = pix_cnt_q;
    slice_cnt_d = slice_cnt_q;
    timer_d     = timer_q;
    result_d    = result_q;
    guard_d     = guard_q;
    frame_err_d = 1'b0;
    case (state_q)
      RX_WAIT: begin
        // An arriving byte takes priority over a simultaneous timeout.
        if (rx_rdy) begin
          shift_d     = rx_data;
          slice_cnt_d = '0;
          timer_d     = '0;
          state_d     = UNPACK;
        end else if (pix_cnt_q != '0 && TO_CYC != 0) begin
          if (timer_q == TO_LAST) begin
            pix_cnt_d   = '0;
            timer_d     = '0;
            frame_err_d = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      UNPACK: begin
        shift_d     = shift_q >> PIX_W;
        slice_cnt_d = slice_cnt_q + 4'd1;
        timer_d     = '0;
        // Overrun: the byte is dropped, the frame carries on.
        if (rx_rdy) frame_err_d = 1'b1;
        if (pix_cnt_q == LAST_PIX) begin
          // Hold the counter at the last address; START clears it.
          state_d = START;
        end else begin
          pix_cnt_d = pix_cnt_q + ADDR_W'(1);
          if (slice_cnt_q == LAST_SLICE) state_d = RX_WAIT;
        end
      end
      START: begin
        pix_cnt_d = '0;
        state_d   = CORE;
      end
      CORE: begin
        if (core_done) begin
          result_d = core_result;
          state_d  = TX;
        end
      end
      TX: begin
        guard_d = 1'b1;
        state_d = TX_WAIT;
      end
      TX_WAIT: begin
        // First cycle ignores tx_rdy: the UART has not yet seen tx_start.
        if (guard_q) guard_d = 1'b0;
        else if (tx_rdy) state_d = RX_WAIT;
      end
      default: state_d = RX_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RX_WAIT;
      shift_q     <= '0;
      pix_cnt_q   <= '0;
      slice_cnt_q <= '0;
      timer_q     <= '0;
      result_q    <= '0;
      guard_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      pix_cnt_q   <= pix_cnt_d;
      slice_cnt_q <= slice_cnt_d;
      timer_q     <= timer_d;
      result_q    <= result_d;
      guard_q     <= guard_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign tx_enc = (ASCII != 0) ? (8'h30 + 8'(result_q)) : 8'(result_q);

  // Outputs decode directly from registered state so an async reset
  // removes the write strobe immediately.
  assign ram_we     = (state_q == UNPACK);
  assign ram_addr   = ram_we ? pix_cnt_q : '0;
  assign ram_wdata  = ram_we ? shift_q[PIX_W-1:0] : '0;
  assign core_start = (state_q == START);
  assign tx_start   = (state_q == TX);
  assign tx_data    = (state_q == TX || state_q == TX_WAIT) ? tx_enc : 8'h00;
  assign result     = result_q;
  assign busy       = !(state_q == RX_WAIT && pix_cnt_q == '0);
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_snn_frame_ctrl.sv
module tb_snn_frame_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: 1-bit pixels, 784-pixel frame, short timeout, ASCII result.
  logic       rx_rdy_a, core_done_a, tx_rdy_a;
  logic [7:0] rx_data_a, tx_data_a;
  logic       ram_we_a, core_start_a, tx_start_a, busy_a, frame_err_a;
  logic [9:0] ram_addr_a;
  logic [0:0] ram_wdata_a;
  logic [3:0] core_result_a, result_a;
  // Instance B: 4-bit pixels, 5-pixel frame, no timeout, binary result.
  logic       rx_rdy_b, core_done_b, tx_rdy_b;
  logic [7:0] rx_data_b, tx_data_b;
  logic       ram_we_b, core_start_b, tx_start_b, busy_b, frame_err_b;
  logic [9:0] ram_addr_b;
  logic [3:0] ram_wdata_b;
  logic [3:0] core_result_b, result_b;

  snn_frame_ctrl #(.PIX_W(1), .N_PIX(784), .ADDR_W(10), .RES_W(4), .TO_CYC(100), .ASCII(1)) dut_a (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy_a), .rx_data(rx_data_a),
    .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a),
    .core_start(core_start_a), .core_done(core_done_a), .core_result(core_result_a),
    .tx_start(tx_start_a), .tx_data(tx_data_a), .tx_rdy(tx_rdy_a),
    .result(result_a), .busy(busy_a), .frame_err(frame_err_a));

  snn_frame_ctrl #(.PIX_W(4), .N_PIX(5), .ADDR_W(10), .RES_W(4), .TO_CYC(0), .ASCII(0)) dut_b (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy_b), .rx_data(rx_data_b),
    .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
    .core_start(core_start_b), .core_done(core_done_b), .core_result(core_result_b),
    .tx_start(tx_start_b), .tx_data(tx_data_b), .tx_rdy(tx_rdy_b),
    .result(result_b), .busy(busy_b), .frame_err(frame_err_b));

  int checks = 0, errors = 0;
  int cyc = 0;
  int qa[$], qb[$];          // expected writes, encoded addr*256+data
  int txa[$], txb[$];        // expected transmitted bytes
  int starts[2], errs[2], exp_st[2], mp[2], lastw[2];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mon_wr(int s, int addr, int data);
    int e;
    int n;
    n = (s == 0) ? 784 : 5;
    if ((s == 0 && qa.size() == 0) || (s == 1 && qb.size() == 0)) begin
      chk("unexpected_write", 1, 0);
    end else begin
      if (s == 0) e = qa.pop_front(); else e = qb.pop_front();
      chk("wr_addr", addr, e >> 8);
      chk("wr_data", data, e & 255);
      if (addr == n - 1) lastw[s] = cyc;
    end
  endtask

  task automatic mon_tx(int s, int data);
    if ((s == 0 && txa.size() == 0) || (s == 1 && txb.size() == 0))
      chk("unexpected_tx", 1, 0);
    else if (s == 0) chk("tx_data_a", data, txa.pop_front());
    else chk("tx_data_b", data, txb.pop_front());
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each event.
  always @(negedge clk) begin
    cyc++;
    if (ram_we_a) mon_wr(0, int'(ram_addr_a), int'(ram_wdata_a));
    else chk("idle_addr_a", int'(ram_addr_a), 0);
    if (ram_we_b) mon_wr(1, int'(ram_addr_b), int'(ram_wdata_b));
    else chk("idle_addr_b", int'(ram_addr_b), 0);
    if (core_start_a) begin starts[0]++; chk("start_lat_a", cyc - lastw[0], 1); end
    if (core_start_b) begin starts[1]++; chk("start_lat_b", cyc - lastw[1], 1); end
    if (frame_err_a) errs[0]++;
    if (frame_err_b) errs[1]++;
    if (tx_start_a) mon_tx(0, int'(tx_data_a));
    if (tx_start_b) mon_tx(1, int'(tx_data_b));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rx(int s, logic [7:0] b);
    if (s == 0) begin rx_rdy_a = 1'b1; rx_data_a = b; end
    else begin rx_rdy_b = 1'b1; rx_data_b = b; end
    tick;
    rx_rdy_a = 1'b0;
    rx_rdy_b = 1'b0;
  endtask

  // Reference: a byte yields 8/PIX_W pixels LSB first until the frame fills.
  task automatic model_byte(int s, logic [7:0] b);
    int pw, n, d;
    pw = (s == 0) ? 1 : 4;
    n  = (s == 0) ? 784 : 5;
    for (int i = 0; i < 8 / pw; i++) begin
      d = (int'(b) >> (i * pw)) & ((1 << pw) - 1);
      if (s == 0) qa.push_back((mp[s] << 8) | d); else qb.push_back((mp[s] << 8) | d);
      if (mp[s] == n - 1) begin
        mp[s] = 0;
        exp_st[s]++;
        break;
      end
      mp[s]++;
    end
  endtask

  task automatic put_byte(int s, logic [7:0] b);
    model_byte(s, b);
    pulse_rx(s, b);
    repeat (8 + $urandom_range(0, 2)) tick;
  endtask

  task automatic do_core(int s, int r);
    int w, e0;
    logic [7:0] ex;
    w = 0;
    e0 = errs[s];
    while (starts[s] != exp_st[s] && w < 100) begin tick; w++; end
    chk("core_start_count", starts[s], exp_st[s]);
    ex = (s == 0) ? 8'(8'h30 + r) : 8'(r);
    pulse_rx(s, 8'($urandom));          // arrives in CORE: must be ignored
    tick;
    if (s == 0) begin txa.push_back(int'(ex)); core_done_a = 1'b1; core_result_a = 4'(r); end
    else begin txb.push_back(int'(ex)); core_done_b = 1'b1; core_result_b = 4'(r); end
    tick;                               // now in TX
    core_done_a = 1'b0;
    core_done_b = 1'b0;
    tick;                               // guard cycle, tx_rdy already high
    pulse_rx(s, 8'($urandom));          // arrives in TX_WAIT: ignored
    chk("busy_after_guard", int'(s == 0 ? busy_a : busy_b), 1);
    chk("tx_data_held", int'(s == 0 ? tx_data_a : tx_data_b), int'(ex));
    tick;
    chk("busy_idle", int'(s == 0 ? busy_a : busy_b), 0);
    chk("result_held", int'(s == 0 ? result_a : result_b), r);
    chk("no_err_in_frame", errs[s], e0);
    chk("writes_drained", (s == 0) ? qa.size() : qb.size(), 0);
    chk("tx_drained", (s == 0) ? txa.size() : txb.size(), 0);
  endtask

  task automatic frame(int s, int nb, int r, bit fixed, logic [7:0] fb);
    for (int k = 0; k < nb; k++) put_byte(s, fixed ? fb : 8'($urandom));
    do_core(s, r);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, w;
    logic [7:0] b;
    rx_rdy_a = 0; rx_data_a = 0; core_done_a = 0; core_result_a = 0; tx_rdy_a = 1;
    rx_rdy_b = 0; rx_data_b = 0; core_done_b = 0; core_result_b = 0; tx_rdy_b = 1;
    for (int i = 0; i < 2; i++) begin
      starts[i] = 0; errs[i] = 0; exp_st[i] = 0; mp[i] = 0; lastw[i] = -10;
    end
    rst = 1'b1;
    repeat (3) tick;
    chk("rst_ram_we", int'(ram_we_a), 0);
    chk("rst_core_start", int'(core_start_a), 0);
    chk("rst_tx_start", int'(tx_start_a), 0);
    chk("rst_tx_data", int'(tx_data_a), 0);
    chk("rst_result", int'(result_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_frame_err", int'(frame_err_a), 0);
    chk("rst_busy_b", int'(busy_b), 0);
    rst = 1'b0;
    tick;

    frame(0, 98, 7, 1'b1, 8'hA5);
    frame(0, 98, $urandom_range(0, 9), 1'b0, 8'h00);

    // Inter-byte timeout on a partial frame.
    for (int k = 0; k < 3; k++) put_byte(0, 8'($urandom));
    chk("partial_busy", int'(busy_a), 1);
    e0 = errs[0];
    w = 0;
    while (errs[0] == e0 && w < 400) begin tick; w++; end
    chk("timeout_err", errs[0] - e0, 1);
    chk("timeout_latency_ok", int'(w >= 97 && w <= 103), 1);
    repeat (3) tick;
    chk("timeout_single_pulse", errs[0] - e0, 1);
    chk("timeout_busy", int'(busy_a), 0);
    mp[0] = 0;
    frame(0, 98, $urandom_range(0, 9), 1'b0, 8'h00);

    // Overrun two cycles after an accepted byte.
    e0 = errs[0];
    b = 8'($urandom);
    model_byte(0, b);
    pulse_rx(0, b);
    tick;
    pulse_rx(0, 8'hFF);
    repeat (8) tick;
    chk("overrun_err", errs[0] - e0, 1);
    chk("overrun_busy", int'(busy_a), 1);
    frame(0, 97, $urandom_range(0, 9), 1'b0, 8'h00);

    // Reset while unpacking the byte that covers address 300.
    for (int k = 0; k < 37; k++) put_byte(0, 8'($urandom));
    b = 8'($urandom);
    model_byte(0, b);
    pulse_rx(0, b);
    w = 0;
    while (!(ram_we_a && ram_addr_a == 10'd300) && w < 20) begin @(negedge clk); w++; end
    chk("reach_addr300", int'(ram_addr_a), 300);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_we", int'(ram_we_a), 0);
    chk("rst_async_busy", int'(busy_a), 0);
    qa.delete();
    mp[0] = 0;
    repeat (3) tick;
    rst = 1'b0;
    repeat (4) tick;
    frame(0, 98, $urandom_range(0, 9), 1'b0, 8'h00);

    // Instance B: nibble unpacking, truncated last byte, binary result.
    put_byte(1, 8'h21);
    put_byte(1, 8'h43);
    put_byte(1, 8'hF5);
    do_core(1, 9);
    frame(1, 3, $urandom_range(0, 15), 1'b0, 8'h00);
    frame(1, 3, $urandom_range(0, 15), 1'b0, 8'h00);

    repeat (5) tick;
    chk("final_frames_a", starts[0], 5);
    chk("final_frames_b", starts[1], 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
